// File: rtl/tile_hit_judge.sv
// rtl/tile_hit_judge.sv - strike-line hit/miss judge, score keeper and game FSM
//
// Purpose:
//    Samples the four lane tile positions and the current keycode once per
//    frame, judges key presses as hits or misses, detects armed tiles that
//    scroll past the strike line, keeps score / miss count and runs the
//    IDLE/PLAY/OVER game FSM. Every output is registered.
//
// Ports:
//    frame_clk  in   1   frame-rate clock
//    Reset      in   1   synchronous, active-high reset
//    Start      in   1   level; begins or restarts a game from IDLE/OVER
//    keycode    in   8   current keycode, 0 = none
//    TileY      in  40   lane n tile centre Y at [10n+9:10n]
//    TileS      in  10   tile half-height, shared by all lanes
//    Score      out 16   hit count, saturating
//    Misses     out  4   miss count, saturating at 15
//    GameOver   out  1   high in OVER
//    Playing    out  1   high in PLAY
//    HitPulse   out  4   one-cycle per-lane hit strobe
//    Respawn    out  4   one-cycle per-lane respawn request
//
// Build option:
//    COMBO_EN  adds a 6-bit combo counter; hits made with a pre-hit combo of
//              8 or more score 2 instead of 1.

module tile_hit_judge #(
   parameter int          HIT_Y_MIN  = 380,
   parameter int          HIT_Y_MAX  = 460,
   parameter int          MISS_Y     = 470,
   parameter int          MAX_MISSES = 3,
   parameter logic [7:0]  KEY_L0     = 8'h04,
   parameter logic [7:0]  KEY_L1     = 8'h16,
   parameter logic [7:0]  KEY_L2     = 8'h07,
   parameter logic [7:0]  KEY_L3     = 8'h09
) (
   input  logic         frame_clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [7:0]   keycode,
   input  logic [39:0]  TileY,
   input  logic [9:0]   TileS,
   output logic [15:0]  Score,
   output logic [3:0]   Misses,
   output logic         GameOver,
   output logic         Playing,
   output logic [3:0]   HitPulse,
   output logic [3:0]   Respawn
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   localparam logic [10:0] WIN_MIN  = 11'(HIT_Y_MIN);
   localparam logic [10:0] WIN_MAX  = 11'(HIT_Y_MAX);
   localparam logic [10:0] PASS_Y   = 11'(MISS_Y);
   localparam logic [3:0]  MISS_END = 4'(MAX_MISSES);

   logic [1:0]       state;
   logic [7:0]       prev_key;
   logic [3:0]       armed;

   logic [3:0][10:0] bottom;
   logic [3:0]       in_win;
   logic             press;
   logic [1:0]       press_lane;
   logic [3:0]       hit_vec;
   logic [3:0]       resp_vec;
   logic [3:0]       armed_nx;
   logic [2:0]       miss_cnt;
   logic [1:0]       score_inc;
   logic [4:0]       miss_sum;
   logic [3:0]       misses_nx;
   logic [16:0]      score_sum;
   logic [15:0]      score_nx;

   // Tile bottom edge, 11 bits so centre + half-height never wraps.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         bottom[n] = {1'b0, TileY[10*n +: 10]} + {1'b0, TileS};
         in_win[n] = (bottom[n] >= WIN_MIN) && (bottom[n] <= WIN_MAX);
      end
   end

   // A press is a fresh, non-zero keycode that maps onto a lane; holding a
   // key therefore produces exactly one event.
   always_comb begin
      press      = 1'b0;
      press_lane = 2'd0;
      if ((keycode != prev_key) && (keycode != 8'd0)) begin
         if (keycode == KEY_L0) begin
            press      = 1'b1;
            press_lane = 2'd0;
         end else if (keycode == KEY_L1) begin
            press      = 1'b1;
            press_lane = 2'd1;
         end else if (keycode == KEY_L2) begin
            press      = 1'b1;
            press_lane = 2'd2;
         end else if (keycode == KEY_L3) begin
            press      = 1'b1;
            press_lane = 2'd3;
         end
      end
   end

   // Judging for one PLAY cycle. Pass-misses and re-arming use the current
   // armed flags; a hit needs an in-window bottom, which can never also be a
   // pass-miss, so the two never fight over the same lane.
   always_comb begin
      hit_vec  = 4'b0000;
      resp_vec = 4'b0000;
      armed_nx = armed;
      miss_cnt = 3'd0;
      for (int n = 0; n < 4; n++) begin
         if (armed[n] && (bottom[n] >= PASS_Y)) begin
            resp_vec[n] = 1'b1;
            armed_nx[n] = 1'b0;
            miss_cnt    = miss_cnt + 3'd1;
         end else if (bottom[n] < WIN_MIN) begin
            armed_nx[n] = 1'b1;
         end
      end
      if (press) begin
         if (armed[press_lane] && in_win[press_lane]) begin
            hit_vec[press_lane]  = 1'b1;
            resp_vec[press_lane] = 1'b1;
            armed_nx[press_lane] = 1'b0;
         end else begin
            miss_cnt = miss_cnt + 3'd1;
         end
      end
   end

`ifdef COMBO_EN
   logic [5:0] combo;

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         combo <= 6'd0;
      end else if (state == ST_PLAY) begin
         if (miss_cnt != 3'd0) begin
            combo <= 6'd0;
         end else if ((|hit_vec) && (combo != 6'd63)) begin
            combo <= combo + 6'd1;
         end
      end else if (Start) begin
         combo <= 6'd0;
      end
   end

   assign score_inc = (|hit_vec) ? ((combo >= 6'd8) ? 2'd2 : 2'd1) : 2'd0;
`else
   assign score_inc = {1'b0, |hit_vec};
`endif

   always_comb begin
      miss_sum  = {1'b0, Misses} + {2'b00, miss_cnt};
      misses_nx = miss_sum[4] ? 4'hF : miss_sum[3:0];
      score_sum = {1'b0, Score} + {15'd0, score_inc};
      score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         prev_key <= 8'd0;
         armed    <= 4'b1111;
         Score    <= 16'd0;
         Misses   <= 4'd0;
         GameOver <= 1'b0;
         Playing  <= 1'b0;
         HitPulse <= 4'b0000;
         Respawn  <= 4'b0000;
      end else begin
         prev_key <= keycode;
         HitPulse <= 4'b0000;
         Respawn  <= 4'b0000;
         case (state)
            ST_IDLE, ST_OVER: begin
               if (Start) begin
                  state    <= ST_PLAY;
                  Playing  <= 1'b1;
                  GameOver <= 1'b0;
                  Score    <= 16'd0;
                  Misses   <= 4'd0;
                  armed    <= 4'b1111;
               end
            end
            ST_PLAY: begin
               HitPulse <= hit_vec;
               Respawn  <= resp_vec;
               armed    <= armed_nx;
               Score    <= score_nx;
               Misses   <= misses_nx;
               // The ending cycle still delivers its score and respawns.
               if (misses_nx >= MISS_END) begin
                  state    <= ST_OVER;
                  Playing  <= 1'b0;
                  GameOver <= 1'b1;
               end
            end
            default: begin
               state    <= ST_IDLE;
               Playing  <= 1'b0;
               GameOver <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_hit_judge.sv
// tb/tb_tile_hit_judge.sv - self-checking bench for tile_hit_judge

module tb_tile_hit_judge;

   logic         frame_clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic [7:0]   keycode;
   logic [39:0]  TileY;
   logic [9:0]   TileS;
   logic [15:0]  Score;
   logic [3:0]   Misses;
   logic         GameOver;
   logic         Playing;
   logic [3:0]   HitPulse;
   logic [3:0]   Respawn;

   int n_vec = 0;
   int n_bad = 0;

`ifdef COMBO_EN
   localparam bit COMBO = 1'b1;
`else
   localparam bit COMBO = 1'b0;
`endif

   tile_hit_judge dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .Start     (Start),
      .keycode   (keycode),
      .TileY     (TileY),
      .TileS     (TileS),
      .Score     (Score),
      .Misses    (Misses),
      .GameOver  (GameOver),
      .Playing   (Playing),
      .HitPulse  (HitPulse),
      .Respawn   (Respawn)
   );

   always #5 frame_clk = ~frame_clk;

   // Reference model: game rules expressed with plain integers.
   bit       m_play, m_over;
   int       m_score, m_misses, m_combo, m_prev;
   bit [3:0] m_armed, m_hp, m_rs;

   function automatic int lane_of(input int k);
      case (k)
         8'h04:   return 0;
         8'h16:   return 1;
         8'h07:   return 2;
         8'h09:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_step(input bit r, input bit s, input int k,
                             input logic [39:0] ty, input int ts);
      int       b[4];
      int       lane;
      int       add;
      bit       hit;
      bit [3:0] was;
      if (r) begin
         m_play = 0; m_over = 0; m_score = 0; m_misses = 0; m_combo = 0;
         m_prev = 0; m_armed = 4'b1111; m_hp = 0; m_rs = 0;
         return;
      end
      m_hp = 0;
      m_rs = 0;
      if (m_play) begin
         add  = 0;
         hit  = 0;
         was  = m_armed;
         lane = lane_of(k);
         for (int n = 0; n < 4; n++) b[n] = int'(ty[n*10 +: 10]) + ts;
         if (k != m_prev && k != 0 && lane >= 0) begin
            if (was[lane] && b[lane] >= 380 && b[lane] <= 460) begin
               hit = 1; m_hp[lane] = 1; m_rs[lane] = 1; m_armed[lane] = 0;
            end else begin
               add++;
            end
         end
         for (int n = 0; n < 4; n++) begin
            if (was[n] && b[n] >= 470) begin
               m_rs[n] = 1; m_armed[n] = 0; add++;
            end else if (b[n] < 380) begin
               m_armed[n] = 1;
            end
         end
         if (hit) m_score = m_score + ((COMBO && m_combo >= 8) ? 2 : 1);
         if (m_score > 65535) m_score = 65535;
         if (add > 0) m_combo = 0;
         else if (hit && m_combo < 63) m_combo++;
         m_misses = m_misses + add;
         if (m_misses > 15) m_misses = 15;
         if (m_misses >= 3) begin
            m_play = 0; m_over = 1;
         end
      end else if (s) begin
         m_play = 1; m_over = 0; m_score = 0; m_misses = 0; m_combo = 0;
         m_armed = 4'b1111;
      end
      m_prev = k;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input int sc, input int mi,
                            input bit ov, input bit pl, input bit [3:0] hp, input bit [3:0] rs);
      check({tag, " Score"},    32'(Score),    32'(sc));
      check({tag, " Misses"},   32'(Misses),   32'(mi));
      check({tag, " GameOver"}, 32'(GameOver), 32'(ov));
      check({tag, " Playing"},  32'(Playing),  32'(pl));
      check({tag, " HitPulse"}, 32'(HitPulse), 32'(hp));
      check({tag, " Respawn"},  32'(Respawn),  32'(rs));
   endtask

   task automatic check_model(input string tag);
      check_out(tag, m_score, m_misses, m_over, m_play, m_hp, m_rs);
   endtask

   task automatic drive(input bit r, input bit s, input logic [7:0] k,
                        input logic [39:0] ty, input logic [9:0] ts);
      @(negedge frame_clk);
      Reset = r; Start = s; keycode = k; TileY = ty; TileS = ts;
      @(posedge frame_clk);
      model_step(r, s, int'(k), ty, int'(ts));
      #1;
   endtask

   function automatic logic [39:0] py(input int a, input int b, input int c, input int d);
      return {10'(d), 10'(c), 10'(b), 10'(a)};
   endfunction

   typedef struct {
      bit          rst;
      bit          start;
      logic [7:0]  key;
      logic [39:0] ty;
      int          score;
      int          misses;
      bit          over;
      bit          play;
      bit [3:0]    hp;
      bit [3:0]    rs;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit s, input logic [7:0] k,
                               input logic [39:0] ty, input int sc, input int mi,
                               input bit ov, input bit pl, input bit [3:0] hp, input bit [3:0] rs);
      vec_t v;
      v.rst = r; v.start = s; v.key = k; v.ty = ty; v.score = sc; v.misses = mi;
      v.over = ov; v.play = pl; v.hp = hp; v.rs = rs;
      return v;
   endfunction

   vec_t tbl[30];

   initial begin
      logic [39:0] d, l0, l13, l2f;
      logic [7:0]  k;
      logic [39:0] ty;
      logic [9:0]  ts;
      int          sel;

      Reset = 1'b1; Start = 1'b0; keycode = 8'd0; TileY = '0; TileS = 10'd75;
      model_step(1, 0, 0, '0, 75);

      d   = py(25, 25, 25, 25);     // every bottom at 100, above the window
      l0  = py(330, 25, 25, 25);    // lane 0 bottom 405
      l13 = py(25, 395, 25, 395);   // lanes 1 and 3 bottom 470
      l2f = py(25, 25, 304, 25);    // lane 2 bottom 379

      tbl[0]  = mk(1, 0, 8'h00, d,   0, 0, 0, 0, 4'b0000, 4'b0000);
      tbl[1]  = mk(1, 0, 8'h00, d,   0, 0, 0, 0, 4'b0000, 4'b0000);
      tbl[2]  = mk(0, 1, 8'h00, d,   0, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[3]  = mk(0, 0, 8'h00, l0,  0, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[4]  = mk(0, 0, 8'h04, l0,  1, 0, 0, 1, 4'b0001, 4'b0001);
      tbl[5]  = mk(0, 0, 8'h04, l0,  1, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[6]  = mk(0, 0, 8'h04, l0,  1, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[7]  = mk(0, 0, 8'h04, l0,  1, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[8]  = mk(0, 0, 8'h04, l0,  1, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[9]  = mk(0, 0, 8'h00, d,   1, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[10] = mk(0, 0, 8'h00, l13, 1, 2, 0, 1, 4'b0000, 4'b1010);
      tbl[11] = mk(0, 0, 8'h00, l13, 1, 2, 0, 1, 4'b0000, 4'b0000);
      tbl[12] = mk(0, 0, 8'h00, d,   1, 2, 0, 1, 4'b0000, 4'b0000);
      tbl[13] = mk(0, 0, 8'h16, py(25, 330, 25, 25), 2, 2, 0, 1, 4'b0010, 4'b0010);
      tbl[14] = mk(0, 0, 8'h00, d,   2, 2, 0, 1, 4'b0000, 4'b0000);
      tbl[15] = mk(0, 0, 8'h07, py(25, 25, 200, 25), 2, 3, 1, 0, 4'b0000, 4'b0000);
      tbl[16] = mk(0, 0, 8'h00, l0,  2, 3, 1, 0, 4'b0000, 4'b0000);
      tbl[17] = mk(0, 0, 8'h04, l0,  2, 3, 1, 0, 4'b0000, 4'b0000);
      tbl[18] = mk(0, 1, 8'h00, l0,  0, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[19] = mk(0, 0, 8'h04, l0,  1, 0, 0, 1, 4'b0001, 4'b0001);
      tbl[20] = mk(0, 0, 8'h00, d,   1, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[21] = mk(0, 0, 8'h04, py(305, 25, 25, 25), 2, 0, 0, 1, 4'b0001, 4'b0001);
      tbl[22] = mk(0, 0, 8'h00, d,   2, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[23] = mk(0, 0, 8'h04, py(385, 25, 25, 25), 3, 0, 0, 1, 4'b0001, 4'b0001);
      tbl[24] = mk(0, 0, 8'h00, py(25, 25, 394, 25), 3, 0, 0, 1, 4'b0000, 4'b0000);
      tbl[25] = mk(0, 0, 8'h07, py(25, 25, 386, 25), 3, 1, 0, 1, 4'b0000, 4'b0000);
      tbl[26] = mk(0, 0, 8'h00, l2f, 3, 1, 0, 1, 4'b0000, 4'b0000);
      tbl[27] = mk(0, 0, 8'h07, l2f, 3, 2, 0, 1, 4'b0000, 4'b0000);
      tbl[28] = mk(0, 0, 8'h05, l2f, 3, 2, 0, 1, 4'b0000, 4'b0000);
      tbl[29] = mk(0, 0, 8'h16, py(25, 330, 304, 395), 4, 3, 1, 0, 4'b0010, 4'b1010);

      for (int i = 0; i < 30; i++) begin
         drive(tbl[i].rst, tbl[i].start, tbl[i].key, tbl[i].ty, 10'd75);
         check_out($sformatf("row%0d", i), tbl[i].score, tbl[i].misses,
                   tbl[i].over, tbl[i].play, tbl[i].hp, tbl[i].rs);
      end

      // Reset in the middle of a live game aborts it completely.
      drive(0, 1, 8'h00, l0, 10'd75);
      drive(0, 0, 8'h04, l0, 10'd75);
      check_out("midgame_hit", 1, 0, 0, 1, 4'b0001, 4'b0001);
      drive(1, 0, 8'h00, l0, 10'd75);
      check_out("midgame_reset", 0, 0, 0, 0, 4'b0000, 4'b0000);

`ifdef COMBO_EN
      drive(0, 1, 8'h00, d, 10'd75);
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 8'h04, l0, 10'd75);
         check_model($sformatf("combo_hit%0d", i));
         drive(0, 0, 8'h00, d, 10'd75);
      end
      check("combo_score9", 32'(Score), 32'd10);
      drive(0, 0, 8'h07, py(25, 25, 200, 25), 10'd75);
      check_model("combo_miss");
      drive(0, 0, 8'h00, d, 10'd75);
      drive(0, 0, 8'h04, l0, 10'd75);
      check("combo_after_miss", 32'(Score), 32'd11);
`endif

      // Randomised play against the model.
      drive(1, 0, 8'h00, d, 10'd75);
      k = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2, 3: k = 8'h00;
            4, 5:       k = k;
            6:          k = 8'h04;
            7:          k = 8'h16;
            8:          k = ($urandom_range(0, 1) == 0) ? 8'h07 : 8'h09;
            default:    k = 8'($urandom);
         endcase
         ty = {10'($urandom_range(0, 430)), 10'($urandom_range(0, 430)),
               10'($urandom_range(0, 430)), 10'($urandom_range(0, 430))};
         ts = 10'($urandom_range(20, 60));
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, k, ty, ts);
         check_model($sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tile_hit_judge.md
Name: tile_hit_judge

Overview:
- Downstream consumer of the per-lane tile movers. Each frame it samples the four tile positions and the current USB keycode.
- Judges key presses as hits or misses and detects tiles that scroll past the strike line unhit.
- Keeps score and miss count and runs the game-state FSM (IDLE/PLAY/OVER).
- Issues per-lane respawn pulses back to the tile movers. Score and state outputs feed the colour mapper / HUD.

Parameters:
- HIT_Y_MIN, 380: lowest tile-bottom Y (inclusive) counted as inside the strike window
- HIT_Y_MAX, 460: highest tile-bottom Y (inclusive) inside the strike window
- MISS_Y, 470: tile-bottom Y at or beyond which an unhit, armed tile is a pass-miss
- MAX_MISSES, 3: miss count that ends the game
- KEY_L0, 8'h04: keycode for lane 0 (A)
- KEY_L1, 8'h16: keycode for lane 1 (S)
- KEY_L2, 8'h07: keycode for lane 2 (D)
- KEY_L3, 8'h09: keycode for lane 3 (F)

Ports:
- frame_clk  in  1  frame-rate clock, the only clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  level; begins or restarts a game
- keycode  in  8  current keycode, 0 = none
- TileY  in  40  lane n tile centre Y at bits [10n+9:10n]
- TileS  in  10  tile half-height, shared by all lanes
- Score  out  16  hits, saturating
- Misses  out  4  miss count
- GameOver  out  1  high in OVER
- Playing  out  1  high in PLAY
- HitPulse  out  4  one-cycle per-lane hit strobe
- Respawn  out  4  one-cycle per-lane respawn request

Behaviour:
- Reset (sync, frame_clk edge) clears everything: state=IDLE, Score=0, Misses=0, GameOver=0, Playing=0, HitPulse=0, Respawn=0, prev_key=0, all lanes armed=1. Reset mid-game aborts the game the same way.
- All outputs are registered. Every decision reflects the inputs sampled on the same edge and is visible one cycle later.
- Tile bottom: B[n] = TileY[n] + TileS, computed 11 bits wide with no wrap. In-window: HIT_Y_MIN <= B <= HIT_Y_MAX.
- Press event: keycode != prev_keycode, keycode != 0, and keycode matches a lane key. prev_keycode updates every cycle. A held key gives exactly one event. A non-lane keycode gives no event.
- FSM:
  - IDLE: Start=1 -> PLAY, with Score, Misses and armed cleared to reset values.
  - PLAY: judging is active.
  - OVER: outputs held, no judging. Start=1 -> PLAY with counters cleared.
- PLAY, press on lane k:
  - Lane k armed and in-window: HitPulse[k]=1, Respawn[k]=1, Score+1 (saturates at 16'hFFFF), armed[k]=0.
  - Otherwise: Misses+1.
- PLAY, pass-miss: any lane n with armed[n]=1 and B[n] >= MISS_Y gives Respawn[n]=1, armed[n]=0, and counts as one miss.
- Re-arm: armed[n] returns to 1 when B[n] < HIT_Y_MIN, i.e. the respawned tile is above the window.
- Simultaneous events: Misses increases by the total of all miss events in the cycle (press-miss plus pass-misses), saturating at 15.
- A hit and a pass-miss on different lanes in the same cycle are both applied.
- If the updated Misses >= MAX_MISSES, the next state is OVER. The final Score and the final Respawn pulses of that cycle are still applied.
- Playing = (state==PLAY). GameOver = (state==OVER).

Optional Feature:
- Macro COMBO_EN.
- Defined: adds a 6-bit combo counter. A hit increments it (saturating at 63); any miss clears it. When the pre-increment combo >= 8, a hit adds 2 to Score instead of 1, still saturating. Combo resets with Reset and on Start.
- Undefined: no combo logic; every hit adds exactly 1.

Test Plan:
- Reset=1 for 2 cycles, then Start=1 -> Playing=1 next cycle; Score=0, Misses=0, all pulses 0.
- Lane 0 TileY=330, TileS=75 (B=405); keycode 0 -> 8'h04 -> HitPulse=4'b0001, Respawn=4'b0001, Score=1. Hold 8'h04 for 5 cycles -> no further change.
- Lane 2 TileY=200 (B=275), keycode 8'h07 -> Misses=1, Score unchanged, HitPulse=0.
- Lanes 1 and 3 armed, both stepped to B=470 on the same cycle -> Respawn=4'b1010, Misses increases by 2. Lanes re-arm once B drops to 100.
- Three misses total -> GameOver=1, Playing=0. Further presses change nothing. Start -> PLAY with Score=0, Misses=0.
- COMBO_EN defined: 9 consecutive in-window hits -> Score=10 (8×1 + 1×2). Next press-miss clears combo; the following hit adds 1.
